// File: rtl/keypad_lock_pkg.sv
// Shared types for the parameterised keypad lock: FSM state enum (whose values
// are also the state_out encodings) and a small sizing helper.
package keypad_lock_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StLocked   = 3'd0,
        StEntry    = 3'd1,
        StCheck    = 3'd2,
        StUnlocked = 3'd3,
        StLockout  = 3'd4
    } lock_state_t;

    // Largest of three cycle counts; sizes the shared timer.
    function automatic int unsigned maxOf3(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done is high while the count is zero. One instance
// serves the unlock window, the entry timeout and the lockout period.
module lock_timer #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic             done
);

    logic [WIDTH-1:0] countQ;

    // Load takes priority; otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            countQ <= '0;
        end else if (load) begin
            countQ <= loadValue;
        end else if (countQ != '0) begin
            countQ <= countQ - 1'b1;
        end
    end

    assign done = (countQ == '0);

endmodule

// File: rtl/param_keypad_lock.sv
// Parameterised keypad door lock. Digits are compared as they arrive and any
// mismatch is remembered in a sticky flag, so the full entry is never stored.
// Optional feature: define KEYPAD_LOCKOUT_EN to enter a timed lockout after
// MAX_FAIL consecutive failures; without it fail_count just saturates.
module param_keypad_lock
    import keypad_lock_pkg::*;
#(
    parameter int unsigned                      CODE_LEN       = 4,
    parameter int unsigned                      DIGIT_W        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]      RESET_CODE     = 16'h1337,
    parameter int unsigned                      KEY_REQ        = 0,
    parameter int unsigned                      UNLOCK_CYCLES  = 8,
    parameter int unsigned                      ENTRY_TIMEOUT  = 32,
    parameter int unsigned                      MAX_FAIL       = 3,
    parameter int unsigned                      LOCKOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            digit_valid,
    input  logic [DIGIT_W-1:0]              digit,
    input  logic                            key_in,
    input  logic                            code_we,
    input  logic [$clog2(CODE_LEN)-1:0]     code_idx,
    input  logic [DIGIT_W-1:0]              code_wdata,
    output logic                            door_unlocked,
    output logic                            door_locked,
    output logic                            bad_code,
    output logic [StateW-1:0]               state_out,
    output logic [$clog2(CODE_LEN+1)-1:0]   digit_count,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

    localparam int unsigned CntW   = $clog2(CODE_LEN + 1);
    localparam int unsigned IdxW   = $clog2(CODE_LEN);
    localparam int unsigned FailW  = $clog2(MAX_FAIL + 1);
    localparam int unsigned TimerW = $clog2(maxOf3(UNLOCK_CYCLES, ENTRY_TIMEOUT,
                                                   LOCKOUT_CYCLES) + 1);

    // Loading N-1 makes the state last N cycles, leaving on the done cycle.
    localparam logic [TimerW-1:0] UnlockLoad  = TimerW'(UNLOCK_CYCLES - 1);
    localparam logic [TimerW-1:0] EntryLoad   = TimerW'(ENTRY_TIMEOUT - 1);
    localparam logic [TimerW-1:0] LockoutLoad = TimerW'(LOCKOUT_CYCLES - 1);

    lock_state_t        stateQ, stateD;
    logic [CntW-1:0]    digitCountQ, digitCountD;
    logic [FailW-1:0]   failCountQ, failCountD, failIncr;
    logic               mismatchQ, mismatchD;
    logic               badCodeQ, badCodeD;
    logic               codeWrite;
    logic               timerLoad, timerDone;
    logic [TimerW-1:0]  timerLoadValue;
    logic [DIGIT_W-1:0] codeQ [CODE_LEN];

    lock_timer #(
        .WIDTH     (TimerW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timerLoad),
        .loadValue (timerLoadValue),
        .done      (timerDone)
    );

    // State, counters and the one-cycle bad_code register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ      <= StLocked;
            digitCountQ <= '0;
            failCountQ  <= '0;
            mismatchQ   <= 1'b0;
            badCodeQ    <= 1'b0;
        end else begin
            stateQ      <= stateD;
            digitCountQ <= digitCountD;
            failCountQ  <= failCountD;
            mismatchQ   <= mismatchD;
            badCodeQ    <= badCodeD;
        end
    end

    // Stored code; the first digit lives in the most significant RESET_CODE slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CODE_LEN; i++) begin
                codeQ[i] <= RESET_CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
            end
        end else if (codeWrite && (32'(code_idx) < CODE_LEN)) begin
            codeQ[code_idx] <= code_wdata;
        end
    end

    // Next-state, counter updates and timer control.
    always_comb begin
        stateD      = stateQ;
        digitCountD = digitCountQ;
        failCountD  = failCountQ;
        mismatchD   = mismatchQ;
        badCodeD    = 1'b0;
        codeWrite   = 1'b0;
        timerLoad   = 1'b0;
        failIncr    = (32'(failCountQ) >= MAX_FAIL) ? failCountQ : failCountQ + 1'b1;

        case (stateQ)
            StLocked: begin
                if (digit_valid) begin
                    mismatchD   = (digit != codeQ[0]);
                    digitCountD = CntW'(1);
                    timerLoad   = 1'b1;
                    stateD      = StEntry;
                end
            end
            StEntry: begin
                if (digit_valid) begin
                    mismatchD   = mismatchQ | (digit != codeQ[digitCountQ[IdxW-1:0]]);
                    digitCountD = digitCountQ + 1'b1;
                    timerLoad   = 1'b1;
                    if (32'(digitCountQ) == CODE_LEN - 1) begin
                        stateD = StCheck;
                    end
                end else if (timerDone) begin
                    // Silent abort: no bad_code, fail_count untouched.
                    digitCountD = '0;
                    mismatchD   = 1'b0;
                    stateD      = StLocked;
                end
            end
            StCheck: begin
                digitCountD = '0;
                mismatchD   = 1'b0;
                if (!mismatchQ && (key_in || (KEY_REQ == 0))) begin
                    failCountD = '0;
                    timerLoad  = 1'b1;
                    stateD     = StUnlocked;
                end else begin
                    badCodeD   = 1'b1;
                    failCountD = failIncr;
                    stateD     = StLocked;
`ifdef KEYPAD_LOCKOUT_EN
                    if (32'(failIncr) == MAX_FAIL) begin
                        timerLoad = 1'b1;
                        stateD    = StLockout;
                    end
`endif
                end
            end
            StUnlocked: begin
                // Writes are honoured on every unlocked cycle, the last one included.
                codeWrite = code_we;
                if (timerDone) begin
                    stateD = StLocked;
                end
            end
            StLockout: begin
                if (timerDone) begin
                    failCountD = '0;
                    stateD     = StLocked;
                end
            end
            default: begin
                stateD = StLocked;
            end
        endcase

        case (stateD)
            StUnlocked: timerLoadValue = UnlockLoad;
            StLockout:  timerLoadValue = LockoutLoad;
            default:    timerLoadValue = EntryLoad;
        endcase
    end

    assign door_unlocked = (stateQ == StUnlocked);
    assign door_locked   = ~door_unlocked;
    assign bad_code      = badCodeQ;
    assign state_out     = stateQ;
    assign digit_count   = digitCountQ;
    assign fail_count    = failCountQ;

endmodule

// File: tb/tb_param_keypad_lock.sv
// Bench for param_keypad_lock: two instances (KEY_REQ=0 and KEY_REQ=1) share
// all inputs; each is checked every cycle against a digit-list reference model,
// plus table vectors and hand-written corner sequences.
module tb_param_keypad_lock;

`ifdef KEYPAD_LOCKOUT_EN
    localparam bit LockoutEn = 1'b1;
`else
    localparam bit LockoutEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       digitValid;
    logic [3:0] digit;
    logic       keyIn;
    logic       codeWe;
    logic [1:0] codeIdx;
    logic [3:0] codeWdata;

    logic       doorUnl   [2];
    logic       doorLck   [2];
    logic       badCode   [2];
    logic [2:0] stateOut  [2];
    logic [2:0] digitCnt  [2];
    logic [1:0] failCnt   [2];

    int checks = 0;
    int errors = 0;

    param_keypad_lock dut0 (
        .clk           (clk),
        .rst           (rst),
        .digit_valid   (digitValid),
        .digit         (digit),
        .key_in        (keyIn),
        .code_we       (codeWe),
        .code_idx      (codeIdx),
        .code_wdata    (codeWdata),
        .door_unlocked (doorUnl[0]),
        .door_locked   (doorLck[0]),
        .bad_code      (badCode[0]),
        .state_out     (stateOut[0]),
        .digit_count   (digitCnt[0]),
        .fail_count    (failCnt[0])
    );

    param_keypad_lock #(
        .KEY_REQ       (1)
    ) dut1 (
        .clk           (clk),
        .rst           (rst),
        .digit_valid   (digitValid),
        .digit         (digit),
        .key_in        (keyIn),
        .code_we       (codeWe),
        .code_idx      (codeIdx),
        .code_wdata    (codeWdata),
        .door_unlocked (doorUnl[1]),
        .door_locked   (doorLck[1]),
        .bad_code      (badCode[1]),
        .state_out     (stateOut[1]),
        .digit_count   (digitCnt[1]),
        .fail_count    (failCnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0..4 = locked/entry/check/unlocked/lockout, the digits
    // typed so far, and plain cycle counters.
    int mMode  [2];
    int mDig   [2][4];
    int mCnt   [2];
    int mIdle  [2];
    int mLeft  [2];
    int mFail  [2];
    int mBad   [2];
    int mCode  [2][4];
    int kReq   [2] = '{0, 1};

    task automatic modelStep(input int u);
        bit ok;
        if (rst) begin
            mMode[u] = 0; mCnt[u] = 0; mIdle[u] = 0; mLeft[u] = 0;
            mFail[u] = 0; mBad[u] = 0;
            mCode[u][0] = 1; mCode[u][1] = 3; mCode[u][2] = 3; mCode[u][3] = 7;
            return;
        end
        mBad[u] = 0;
        case (mMode[u])
            0: if (digitValid) begin
                mDig[u][0] = int'(digit); mCnt[u] = 1; mIdle[u] = 0; mMode[u] = 1;
            end
            1: begin
                if (digitValid) begin
                    mDig[u][mCnt[u]] = int'(digit);
                    mCnt[u]++;
                    mIdle[u] = 0;
                    if (mCnt[u] == 4) mMode[u] = 2;
                end else begin
                    mIdle[u]++;
                    if (mIdle[u] == 32) begin
                        mMode[u] = 0; mCnt[u] = 0;
                    end
                end
            end
            2: begin
                ok = 1'b1;
                for (int i = 0; i < 4; i++) if (mDig[u][i] != mCode[u][i]) ok = 1'b0;
                if (kReq[u] != 0 && !keyIn) ok = 1'b0;
                mCnt[u] = 0;
                if (ok) begin
                    mMode[u] = 3; mLeft[u] = 8; mFail[u] = 0;
                end else begin
                    mBad[u] = 1;
                    if (mFail[u] < 3) mFail[u]++;
                    if (LockoutEn && mFail[u] == 3) begin
                        mMode[u] = 4; mLeft[u] = 16;
                    end else begin
                        mMode[u] = 0;
                    end
                end
            end
            3: begin
                if (codeWe) mCode[u][codeIdx] = int'(codeWdata);
                mLeft[u]--;
                if (mLeft[u] == 0) mMode[u] = 0;
            end
            default: begin
                mLeft[u]--;
                if (mLeft[u] == 0) begin
                    mMode[u] = 0; mFail[u] = 0;
                end
            end
        endcase
    endtask

    task automatic checkModel(input int u);
        int unl;
        unl = (mMode[u] == 3) ? 1 : 0;
        checks++;
        if (int'(stateOut[u]) != mMode[u] || int'(doorUnl[u]) != unl ||
            int'(doorLck[u]) != 1 - unl || int'(badCode[u]) != mBad[u] ||
            int'(digitCnt[u]) != mCnt[u] || int'(failCnt[u]) != mFail[u]) begin
            errors++;
            $display("FAIL model_dut%0d t=%0t: got st=%0d unl=%0d lck=%0d bad=%0d dc=%0d fc=%0d want st=%0d unl=%0d lck=%0d bad=%0d dc=%0d fc=%0d",
                     u, $time, stateOut[u], doorUnl[u], doorLck[u], badCode[u], digitCnt[u],
                     failCnt[u], mMode[u], unl, 1 - unl, mBad[u], mCnt[u], mFail[u]);
        end
    endtask

    // One clock: model sees the inputs at the edge, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        checkModel(0);
        checkModel(1);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Four digits then the CHECK cycle; returns with post-CHECK outputs visible.
    task automatic enterCode(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            digitValid = 1'b1;
            digit      = c[15-4*i -: 4];
            tick();
        end
        digitValid = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [15:0] code;
        bit          key;
        int          unl0;
        int          unl1;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int unlCycles;
        int badSeen;
        int lockCycles;

        vecs[0] = '{code: 16'h1337, key: 1'b0, unl0: 1, unl1: 0};
        vecs[1] = '{code: 16'h1337, key: 1'b1, unl0: 1, unl1: 1};
        vecs[2] = '{code: 16'h4923, key: 1'b0, unl0: 0, unl1: 0};
        vecs[3] = '{code: 16'h1336, key: 1'b1, unl0: 0, unl1: 0};
        vecs[4] = '{code: 16'h0337, key: 1'b1, unl0: 0, unl1: 0};
        vecs[5] = '{code: 16'hF337, key: 1'b1, unl0: 0, unl1: 0};

        rst = 1'b1; digitValid = 1'b0; digit = '0; keyIn = 1'b0;
        codeWe = 1'b0; codeIdx = '0; codeWdata = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset_state", int'(stateOut[0]), 0);
        chk("reset_locked", int'(doorLck[0]), 1);
        chk("reset_unlocked", int'(doorUnl[0]), 0);
        chk("reset_bad", int'(badCode[0]), 0);
        chk("reset_digit_count", int'(digitCnt[0]), 0);
        chk("reset_fail_count", int'(failCnt[0]), 0);

        // Table vectors: each from reset, outcome right after CHECK.
        for (int v = 0; v < 6; v++) begin
            doReset();
            keyIn = vecs[v].key;
            enterCode(vecs[v].code);
            chk($sformatf("vec%0d_unl0", v), int'(doorUnl[0]), vecs[v].unl0);
            chk($sformatf("vec%0d_bad0", v), int'(badCode[0]), 1 - vecs[v].unl0);
            chk($sformatf("vec%0d_fc0", v), int'(failCnt[0]), 1 - vecs[v].unl0);
            chk($sformatf("vec%0d_st0", v), int'(stateOut[0]), vecs[v].unl0 ? 3 : 0);
            chk($sformatf("vec%0d_unl1", v), int'(doorUnl[1]), vecs[v].unl1);
            chk($sformatf("vec%0d_bad1", v), int'(badCode[1]), 1 - vecs[v].unl1);
            tick();
            chk($sformatf("vec%0d_bad_pulse", v), int'(badCode[0]), 0);
        end

        // Unlock window length and relock.
        doReset();
        keyIn = 1'b0;
        enterCode(16'h1337);
        unlCycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (doorUnl[0]) unlCycles++;
            tick();
        end
        chk("unlock_len", unlCycles, 8);
        chk("relock_locked", int'(doorLck[0]), 1);
        chk("relock_fail", int'(failCnt[0]), 0);

        // Code change, with the last digit written on the final unlocked cycle.
        doReset();
        keyIn = 1'b1;
        enterCode(16'h1337);
        chk("chg_unlocked", int'(doorUnl[0]), 1);
        codeWe = 1'b1;
        codeIdx = 2'd0; codeWdata = 4'd5; tick();
        codeIdx = 2'd1; codeWdata = 4'd2; tick();
        codeIdx = 2'd2; codeWdata = 4'd5; tick();
        codeWe = 1'b0;
        idle(4);
        chk("chg_final_cycle", int'(stateOut[0]), 3);
        codeWe = 1'b1; codeIdx = 2'd3; codeWdata = 4'd0; tick();
        chk("chg_relocked", int'(stateOut[0]), 0);
        codeIdx = 2'd0; codeWdata = 4'd9; tick();
        codeWe = 1'b0;
        enterCode(16'h1337);
        chk("chg_old_code_bad", int'(badCode[0]), 1);
        enterCode(16'h5250);
        chk("chg_new_code_unl0", int'(doorUnl[0]), 1);
        chk("chg_new_code_unl1", int'(doorUnl[1]), 1);
        idle(8);

        // Entry timeout after 32 idle cycles, then reset mid-entry.
        doReset();
        keyIn = 1'b0;
        digitValid = 1'b1; digit = 4'd1; tick();
        digit = 4'd3; tick();
        digitValid = 1'b0;
        badSeen = 0;
        for (int i = 0; i < 31; i++) begin
            tick();
            badSeen |= int'(badCode[0]);
        end
        chk("timeout_before_state", int'(stateOut[0]), 1);
        chk("timeout_before_dc", int'(digitCnt[0]), 2);
        tick();
        badSeen |= int'(badCode[0]);
        chk("timeout_state", int'(stateOut[0]), 0);
        chk("timeout_dc", int'(digitCnt[0]), 0);
        chk("timeout_no_bad", badSeen, 0);
        chk("timeout_fail", int'(failCnt[0]), 0);
        enterCode(16'h4923);
        chk("midrst_pre_fail", int'(failCnt[0]), 1);
        digitValid = 1'b1; digit = 4'd1; tick();
        digit = 4'd3; tick();
        digitValid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_state", int'(stateOut[0]), 0);
        chk("midrst_dc", int'(digitCnt[0]), 0);
        chk("midrst_fail", int'(failCnt[0]), 0);

        // Three consecutive failures.
        doReset();
        keyIn = 1'b0;
        enterCode(16'h4923);
        enterCode(16'h4923);
        enterCode(16'h4923);
        chk("third_fail_bad", int'(badCode[0]), 1);
        chk("third_fail_count", int'(failCnt[0]), 3);
        if (LockoutEn) begin
            chk("lockout_state", int'(stateOut[0]), 4);
            lockCycles = 0;
            codeWe = 1'b1; codeIdx = 2'd0; codeWdata = 4'd8;
            for (int i = 0; i < 40 && stateOut[0] == 3'd4; i++) begin
                digitValid = 1'b1;
                digit = 4'((i % 2 == 0) ? 1 : 3);
                lockCycles++;
                tick();
            end
            digitValid = 1'b0; codeWe = 1'b0;
            chk("lockout_len", lockCycles, 16);
            chk("lockout_exit_state", int'(stateOut[0]), 0);
            chk("lockout_exit_fail", int'(failCnt[0]), 0);
            chk("lockout_exit_dc", int'(digitCnt[0]), 0);
        end else begin
            chk("nolockout_state", int'(stateOut[0]), 0);
            enterCode(16'h4923);
            chk("sat_fail_count", int'(failCnt[0]), 3);
            chk("sat_state", int'(stateOut[0]), 0);
        end
        enterCode(16'h1337);
        chk("after_fails_unl", int'(doorUnl[0]), 1);
        chk("after_fails_fc", int'(failCnt[0]), 0);

        // Randomised run against the model; alternates busy and sparse typing.
        doReset();
        for (int c = 0; c < 4000; c++) begin
            int dvOdds;
            dvOdds = ((c / 256) % 2 == 0) ? 2 : 40;
            rst        = ($urandom_range(0, 699) == 0);
            digitValid = ($urandom_range(0, dvOdds - 1) == 0);
            keyIn      = ($urandom_range(0, 3) != 0);
            if ((mMode[0] == 0 || mMode[0] == 1) && $urandom_range(0, 3) != 0)
                digit = 4'(mCode[0][mCnt[0]]);
            else
                digit = 4'($urandom_range(0, 15));
            codeWe    = ($urandom_range(0, 3) == 0);
            codeIdx   = 2'($urandom_range(0, 3));
            codeWdata = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0; digitValid = 1'b0; codeWe = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_keypad_lock.md
PARAM_KEYPAD_LOCK -- requirements
Module: param_keypad_lock

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4: digits per code entry.
REQ-002 SHALL have parameter DIGIT_W, default 4: bits per digit.
REQ-003 SHALL have parameter RESET_CODE, default 16'h1337, width CODE_LEN*DIGIT_W: power-on code, first digit in MS nibble.
REQ-004 SHALL have parameter KEY_REQ, default 0: 1 = key_in must be high at CHECK for unlock.
REQ-005 SHALL have parameter UNLOCK_CYCLES, default 8: cycles door stays unlocked.
REQ-006 SHALL have parameter ENTRY_TIMEOUT, default 32: idle cycles mid-entry before abort.
REQ-007 SHALL have parameters MAX_FAIL (default 3) and LOCKOUT_CYCLES (default 16).
REQ-008 SHALL have port clk  input  1  rising-edge clock.
REQ-009 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-010 SHALL have port digit_valid  input  1  one-cycle strobe qualifying digit.
REQ-011 SHALL have port digit  input  DIGIT_W  entered digit.
REQ-012 SHALL have port key_in  input  1  physical key present.
REQ-013 SHALL have ports code_we (input 1), code_idx (input $clog2(CODE_LEN)), code_wdata (input DIGIT_W): code digit write.
REQ-014 SHALL have ports door_unlocked (output 1), door_locked (output 1), always complementary.
REQ-015 SHALL have ports bad_code (output 1, one-cycle pulse), state_out (output 3), digit_count (output $clog2(CODE_LEN+1)), fail_count (output $clog2(MAX_FAIL+1)).

Function
REQ-016 SHALL implement states LOCKED, ENTRY, CHECK, UNLOCKED, LOCKOUT; state_out encodes 0..4 respectively.
REQ-017 SHALL, in LOCKED on digit_valid, compare digit to code digit 0, set digit_count=1, enter ENTRY.
REQ-018 SHALL, in ENTRY, compare each valid digit to code[digit_count], OR mismatches into a sticky flag, increment digit_count.
REQ-019 SHALL enter CHECK the cycle after digit_count reaches CODE_LEN; digit_valid in CHECK ignored.
REQ-020 SHALL, in CHECK, go UNLOCKED if no mismatch and (key_in or KEY_REQ==0); door_unlocked high from the next cycle, fail_count cleared.
REQ-021 SHALL, in CHECK otherwise, pulse bad_code one cycle, increment fail_count (saturating at MAX_FAIL), return LOCKED, clear digit_count and mismatch flag.
REQ-022 SHALL hold UNLOCKED exactly UNLOCK_CYCLES cycles then return LOCKED; digits ignored while unlocked.
REQ-023 SHALL accept code_we only in UNLOCKED, writing code_wdata to code[code_idx]; ignored in all other states; write on the final UNLOCKED cycle SHALL still take effect.
REQ-024 SHALL, in ENTRY, abort to LOCKED after ENTRY_TIMEOUT consecutive cycles without digit_valid; no bad_code, fail_count unchanged.
REQ-025 SHALL compare digits as raw DIGIT_W values; no decimal range check.

Reset
REQ-026 SHALL on rst: state LOCKED, door_locked=1, door_unlocked=0, bad_code=0, digit_count=0, fail_count=0, all timers 0, code=RESET_CODE.
REQ-027 SHALL let rst override every other input in any state including mid-entry and LOCKOUT.

Configuration
REQ-028 SHALL, with KEYPAD_LOCKOUT_EN defined, enter LOCKOUT from CHECK when a failure brings fail_count to MAX_FAIL; bad_code still pulses.
REQ-029 SHALL, in LOCKOUT, ignore digit_valid and code_we for LOCKOUT_CYCLES cycles, then enter LOCKED with fail_count=0.
REQ-030 SHALL, without KEYPAD_LOCKOUT_EN, never enter LOCKOUT; fail_count saturates at MAX_FAIL and clears only on success or rst.

Structure
REQ-031 SHALL place state enum (lock_state_t) and state_out encodings in shared package keypad_lock_pkg.
REQ-032 SHALL use one sub-module, lock_timer: loadable down-counter with done flag, shared by unlock, timeout and lockout timing.

Verification
REQ-033 SHALL test: rst, digits 1,3,3,7 key_in=0 -> door_unlocked=1 for 8 cycles, then door_locked=1, fail_count=0.
REQ-034 SHALL test: digits 4,9,2,3 -> bad_code one pulse, fail_count=1, state_out=0.
REQ-035 SHALL test: KEY_REQ=1, digits 1,3,3,7 key_in=0 -> bad_code; repeat with key_in=1 -> unlocked.
REQ-036 SHALL test: unlock, write code 5,2,5,0 via code_we -> 1,3,3,7 fails, 5,2,5,0 unlocks; code_we while locked has no effect.
REQ-037 SHALL test: digits 1,3 then 32 idle cycles -> LOCKED, digit_count=0, no bad_code; rst mid-entry -> same.
REQ-038 SHALL test with KEYPAD_LOCKOUT_EN: three wrong codes -> state_out=4, digits ignored 16 cycles, then 1,3,3,7 unlocks; without macro fail_count stays 3, no lockout.
